// File: rtl/id_pipe.sv
// Instruction-decode stage: register file with write bypass, field decode,
// load-use hazard detection, ID/EX pipeline register and sticky halt state.
module id_pipe #(
    parameter int          DATA_W   = 16,
    parameter int          NREGS    = 16,
    parameter int          ADDR_W   = $clog2(NREGS),
    parameter int          ZERO_REG = 1,
    parameter logic [3:0]  OP_LW    = 4'h8,
    parameter logic [3:0]  OP_SW    = 4'h9,
    parameter logic [3:0]  OP_HLT   = 4'hF
) (
    input  logic              i_clk,
    input  logic              i_nRst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrReg,
    input  logic [DATA_W-1:0] i_wrData,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_port0,
    output logic [DATA_W-1:0] o_port1,
    output logic [DATA_W-1:0] o_sext,
    output logic [ADDR_W-1:0] o_rdReg1,
    output logic [ADDR_W-1:0] o_rdReg2,
    output logic [ADDR_W-1:0] o_wrReg,
    output logic              o_memRd,
    output logic              o_memWr,
    output logic              o_hlt,
    output logic [15:0]       o_stallCnt
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   regs [NREGS];

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   rd, rs, rt;
    logic                is_lw, is_sw, is_hlt;
    logic [DATA_W-1:0]   rs_val, rt_val, sext_val;
    logic                hz;
    logic                zero_en;

    assign zero_en = (ZERO_REG != 0);
    assign opcode  = i_instr[DATA_W-1:DATA_W-4];
    assign rd      = i_instr[ADDR_W+7:8];
    assign rs      = i_instr[ADDR_W+3:4];
    assign rt      = i_instr[ADDR_W-1:0];
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_hlt  = (opcode == OP_HLT);

    // Memory ops carry a 4-bit offset, everything else an 8-bit immediate.
    assign sext_val = (is_lw || is_sw) ? {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]}
                                       : {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]};

    // Stall an instruction that reads the destination of the load now in EX.
    assign hz = i_valid && o_valid && o_memRd && (o_wrReg != '0) &&
                ((o_wrReg == rs) || (o_wrReg == rt));

    assign o_ready = i_nRst && i_valid && !i_stall && !i_flush && !hz && (state == RUN);

    // Register read with same-cycle writeback bypass; r0 reads as zero when hardwired.
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (zero_en && rs == '0)
            rs_val = '0;
        else if (i_wrEn && i_wrReg == rs)
            rs_val = i_wrData;
        if (zero_en && rt == '0)
            rt_val = '0;
        else if (i_wrEn && i_wrReg == rt)
            rt_val = i_wrData;
    end

    // Register file write port; writes to a hardwired r0 are dropped.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (i_wrEn && !(zero_en && i_wrReg == '0)) begin
            regs[i_wrReg] <= i_wrData;
        end
    end

    // Run/halt state register.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst)
            state <= RUN;
        else
            state <= state_next;
    end

    // Once a halt is accepted, only reset brings the stage back to RUN.
    always_comb begin
        state_next = state;
        if (state == RUN && o_ready && is_hlt)
            state_next = HALTED;
    end

    // ID/EX register: flush beats stall beats hazard bubble beats a new load.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            o_valid    <= 1'b0;
            o_instr    <= '0;
            o_pc       <= '0;
            o_port0    <= '0;
            o_port1    <= '0;
            o_sext     <= '0;
            o_rdReg1   <= '0;
            o_rdReg2   <= '0;
            o_wrReg    <= '0;
            o_memRd    <= 1'b0;
            o_memWr    <= 1'b0;
            o_hlt      <= 1'b0;
            o_stallCnt <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (i_stall) begin
            o_valid <= o_valid;
        end else if (hz) begin
            o_valid <= 1'b0;
            o_memRd <= 1'b0;
            o_memWr <= 1'b0;
            if (o_stallCnt != 16'hFFFF)
                o_stallCnt <= o_stallCnt + 16'd1;
        end else if (o_ready) begin
            o_valid  <= 1'b1;
            o_instr  <= i_instr;
            o_pc     <= i_pc;
            o_port0  <= rs_val;
            o_port1  <= rt_val;
            o_sext   <= sext_val;
            o_rdReg1 <= rs;
            o_rdReg2 <= rt;
            o_wrReg  <= rd;
            o_memRd  <= is_lw;
            o_memWr  <= is_sw;
            if (is_hlt)
                o_hlt <= 1'b1;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: bypass, immediates, r0, load-use, stall, flush, halt, reset.
module tb_id_pipe;

    logic        i_clk = 1'b0;
    logic        i_nRst;
    logic        i_valid;
    logic [15:0] i_instr, i_pc;
    logic        i_stall, i_flush;
    logic        i_wrEn;
    logic [3:0]  i_wrReg;
    logic [15:0] i_wrData;
    logic        o_ready, o_valid;
    logic [15:0] o_instr, o_pc, o_port0, o_port1, o_sext;
    logic [3:0]  o_rdReg1, o_rdReg2, o_wrReg;
    logic        o_memRd, o_memWr, o_hlt;
    logic [15:0] o_stallCnt;

    int n_cmp  = 0;
    int n_fail = 0;

    id_pipe dut (
        .i_clk(i_clk), .i_nRst(i_nRst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
        .i_stall(i_stall), .i_flush(i_flush), .i_wrEn(i_wrEn), .i_wrReg(i_wrReg),
        .i_wrData(i_wrData), .o_ready(o_ready), .o_valid(o_valid), .o_instr(o_instr),
        .o_pc(o_pc), .o_port0(o_port0), .o_port1(o_port1), .o_sext(o_sext),
        .o_rdReg1(o_rdReg1), .o_rdReg2(o_rdReg2), .o_wrReg(o_wrReg), .o_memRd(o_memRd),
        .o_memWr(o_memWr), .o_hlt(o_hlt), .o_stallCnt(o_stallCnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        i_valid = v;
        i_instr = ins;
        i_pc    = pc;
        #1;
    endtask

    initial begin
        i_nRst = 1'b0; i_valid = 1'b1; i_instr = 16'h0130; i_pc = 16'h0;
        i_stall = 1'b0; i_flush = 1'b0; i_wrEn = 1'b0; i_wrReg = 4'd0; i_wrData = 16'h0;
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_cnt", o_stallCnt, 0);
        chk("rst_hlt", o_hlt, 0);
        tick(); tick();
        i_nRst = 1'b1;

        // Write r3 and read it through the bypass in the same cycle.
        i_wrEn = 1'b1; i_wrReg = 4'd3; i_wrData = 16'h1234;
        drive(1'b1, 16'h0130, 16'h0100);
        chk("byp_ready", o_ready, 1);
        tick();
        i_wrEn = 1'b0;
        chk("byp_valid", o_valid, 1);
        chk("byp_port0", o_port0, 16'h1234);
        chk("byp_port1", o_port1, 16'h0);
        chk("byp_rdReg1", o_rdReg1, 3);
        chk("byp_wrReg", o_wrReg, 1);
        chk("byp_pc", o_pc, 16'h0100);
        chk("byp_sext", o_sext, 16'h0030);

        // Write to r0 is dropped; rt=3 now comes from the register file.
        i_wrEn = 1'b1; i_wrReg = 4'd0; i_wrData = 16'hFFFF;
        drive(1'b1, 16'h0203, 16'h0102);
        tick();
        i_wrEn = 1'b0;
        chk("r0_byp_port0", o_port0, 16'h0);
        chk("rf_port1", o_port1, 16'h1234);
        drive(1'b1, 16'h0100, 16'h0104);
        tick();
        chk("r0_read_port0", o_port0, 16'h0);

        // Immediates: store offset 4'b1000 and positive 8-bit 0x7F.
        drive(1'b1, 16'h9138, 16'h0106);
        tick();
        chk("sw_sext", o_sext, 16'hFFF8);
        chk("sw_memWr", o_memWr, 1);
        chk("sw_memRd", o_memRd, 0);
        drive(1'b1, 16'h007F, 16'h0108);
        tick();
        chk("imm_sext", o_sext, 16'h007F);
        chk("imm_memWr", o_memWr, 0);

        // Load-use: LW r5, then an instruction reading r5 takes one bubble.
        drive(1'b1, 16'h8530, 16'h010A);
        tick();
        chk("lw_memRd", o_memRd, 1);
        chk("lw_wrReg", o_wrReg, 5);
        drive(1'b1, 16'h0650, 16'h010C);
        chk("hz_ready", o_ready, 0);
        tick();
        chk("hz_valid", o_valid, 0);
        chk("hz_cnt", o_stallCnt, 1);
        chk("hz_memRd", o_memRd, 0);
        chk("hz_ready_after", o_ready, 1);
        tick();
        chk("hz_accept_valid", o_valid, 1);
        chk("hz_accept_instr", o_instr, 16'h0650);

        // EX stall for three cycles holds everything.
        i_stall = 1'b1;
        drive(1'b1, 16'h0130, 16'h010E);
        chk("stall_ready", o_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_valid", o_valid, 1);
            chk("stall_instr", o_instr, 16'h0650);
            chk("stall_pc", o_pc, 16'h010C);
            chk("stall_ready_hold", o_ready, 0);
        end
        i_stall = 1'b0;

        // Flush together with a hazard and a stall: flush wins, counter untouched.
        drive(1'b1, 16'h8530, 16'h0110);
        tick();
        i_stall = 1'b1; i_flush = 1'b1;
        drive(1'b1, 16'h0650, 16'h0112);
        chk("flush_ready", o_ready, 0);
        tick();
        chk("flush_valid", o_valid, 0);
        chk("flush_cnt", o_stallCnt, 1);
        i_stall = 1'b0; i_flush = 1'b0;

        // Halt becomes sticky and blocks further acceptance.
        drive(1'b1, 16'hF000, 16'h0200);
        chk("hlt_ready", o_ready, 1);
        tick();
        chk("hlt_flag", o_hlt, 1);
        chk("hlt_valid", o_valid, 1);
        drive(1'b1, 16'h0130, 16'h0202);
        chk("halted_ready", o_ready, 0);
        tick();
        chk("halted_valid", o_valid, 0);
        i_flush = 1'b1;
        tick();
        chk("halted_hlt_flush", o_hlt, 1);
        i_flush = 1'b0;

        // Asynchronous reset mid-run clears outputs at once.
        i_nRst = 1'b0;
        #1;
        chk("arst_hlt", o_hlt, 0);
        chk("arst_cnt", o_stallCnt, 0);
        chk("arst_instr", o_instr, 0);
        chk("arst_ready", o_ready, 0);
        tick();
        i_nRst = 1'b1;
        drive(1'b1, 16'h0130, 16'h0300);
        chk("post_rst_ready", o_ready, 1);
        tick();
        chk("post_rst_port0", o_port0, 16'h0);
        chk("post_rst_valid", o_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath and instruction width; SHALL be >= 16.
REQ-002 Parameter NREGS, default 16, register count; SHALL be a power of two, 2..16.
REQ-003 Parameter ADDR_W, default log2(NREGS), register address width.
REQ-004 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-005 Clocking SHALL be one clock; reset SHALL be asynchronous, active-low.
REQ-006 i_clk  in  1  clock, all state on rising edge.
REQ-007 i_nRst  in  1  asynchronous active-low reset.
REQ-008 i_valid  in  1  IF presents an instruction.
REQ-009 i_instr, i_pc  in  DATA_W each  instruction and its PC.
REQ-010 i_stall  in  1  EX cannot accept; hold outputs.
REQ-011 i_flush  in  1  squash the ID/EX register (taken branch/jump).
REQ-012 i_wrEn, i_wrReg, i_wrData  in  1/ADDR_W/DATA_W  writeback port.
REQ-013 o_ready  out  1  instruction accepted this cycle.
REQ-014 o_valid  out  1  ID/EX register holds a live instruction.
REQ-015 o_instr, o_pc, o_port0, o_port1, o_sext  out  DATA_W  registered instruction, PC, rs value, rt value, immediate.
REQ-016 o_rdReg1, o_rdReg2, o_wrReg  out  ADDR_W  registered rs, rt, rd.
REQ-017 o_memRd, o_memWr, o_hlt  out  1  registered load, store, sticky halt.
REQ-018 o_stallCnt  out  16  load-use bubble count.

Function
REQ-019 Fields: opcode = i_instr[DATA_W-1:DATA_W-4]; rd = [ADDR_W+7:8]; rs = [ADDR_W+3:4]; rt = [ADDR_W-1:0]; opcode encodings from defines.v (`LW, `SW, `HLT).
REQ-020 o_sext: opcode `LW/`SW -> sign-extend i_instr[3:0] to DATA_W; else sign-extend i_instr[7:0].
REQ-021 Register file: NREGS x DATA_W flops; write on rising edge when i_wrEn; with ZERO_REG=1, writes to 0 ignored and reads of 0 return 0.
REQ-022 Read bypass: rs/rt equal to i_wrReg with i_wrEn (and not zero-reg) SHALL return i_wrData in the same cycle.
REQ-023 Load-use hazard (hz) = o_valid & o_memRd & o_wrReg != 0 & (o_wrReg == rs | o_wrReg == rt) of incoming instruction.
REQ-024 o_ready = i_valid & ~i_stall & ~i_flush & ~hz & state==RUN (combinational).
REQ-025 State machine RUN/HALTED; RUN -> HALTED when an `HLT instruction is accepted; HALTED exits only by reset.
REQ-026 Next ID/EX register, priority order: i_flush -> o_valid<=0, others hold; else i_stall -> all hold; else hz -> o_valid<=0 (bubble), o_stallCnt+1 saturating at 16'hFFFF; else o_ready -> load decoded fields, o_valid<=1; else o_valid<=0.
REQ-027 Latency: accepted instruction SHALL appear on outputs one cycle after acceptance.
REQ-028 o_hlt SHALL assert with the registered `HLT instruction and remain 1 in HALTED regardless of flush/stall.
REQ-029 Flush and hazard in same cycle: flush wins, o_stallCnt unchanged.
REQ-030 Bubble clears o_memRd/o_memWr to 0; other bubble fields don't-care but held.

Reset
REQ-031 On i_nRst low, immediately: all registers and outputs 0, o_stallCnt 0, state RUN, o_ready 0 until i_nRst high.
REQ-032 Reset mid-stall or mid-hazard SHALL discard the held instruction; no pending write survives.

Verification
REQ-033 Write r3=16'h1234, then ADD rs=3 same cycle as write -> o_port0=16'h1234 next cycle (bypass).
REQ-034 `LW rd=5 accepted, next instr rs=5 -> o_ready=0 one cycle, bubble o_valid=0, o_stallCnt=1, instr accepted following cycle.
REQ-035 i_stall=1 for 3 cycles with o_valid=1 -> all outputs unchanged, o_ready=0.
REQ-036 i_flush with hazard and i_stall all high -> o_valid=0 next cycle, o_stallCnt unchanged.
REQ-037 `SW imm 4'b1000 -> o_sext=16'hFFF8; non-mem imm 8'h7F -> 16'h007F; write to r0 then read r0 -> 0.
REQ-038 `HLT accepted -> o_hlt=1, o_ready=0 thereafter; async reset mid-run -> all outputs 0 immediately, state RUN.
